// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg -- shared UART link states and frame constants (rx and tx). Rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5,
    WAIT_IDLE = 3'd6
  } uart_state_t;

  // Start, parity and stop bits wrapped around the data bits.
  localparam int unsigned UART_FRAME_OVERHEAD = 3;
  localparam logic        UART_PARITY_EVEN    = 1'b1;
  localparam logic        UART_IDLE_LEVEL     = 1'b1;

  function automatic int unsigned uart_frame_bits(input int unsigned data_width);
    return data_width + UART_FRAME_OVERHEAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// uart_rx_sync -- 2-flop rx synchronizer, preset to line idle. Built only with
// UART_RX_SYNC_EN defined.                                          Rev 1.0
// ============================================================================
`ifdef UART_RX_SYNC_EN
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= UART_IDLE_LEVEL;
      dout <= UART_IDLE_LEVEL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// uart_receiver -- even-parity UART frame deserialiser, MSB first.
// Option: UART_RX_SYNC_EN adds a 2-flop input synchronizer.          Rev 1.0
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned      IDX_W    = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned      HALF     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic                  rx;
  uart_state_t           state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bad;
  logic                  bit_tick;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx_in),
    .dout  (rx)
  );
`else
  assign rx = rx_in;
`endif

  assign bit_tick = (bit_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par_bad     <= 1'b0;
      rx_data_out <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        // DONE also watches for a start bit so frames may abut the stop bit.
        IDLE, DONE: begin
          if (state == DONE && frame_err) begin
            state <= WAIT_IDLE;
          end else if (rx != UART_IDLE_LEVEL) begin
            busy    <= 1'b1;
            bit_idx <= '0;
            if (HALF == 0) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state   <= START;
              bit_cnt <= CNT_W'(1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        START: begin
          if (bit_cnt == CNT_HALF) begin
            bit_cnt <= '0;
            if (rx == UART_IDLE_LEVEL) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            shift   <= {shift[DATA_WIDTH-2:0], rx};
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            par_bad <= rx ^ (^shift) ^ ~UART_PARITY_EVEN;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            bit_cnt     <= '0;
            rx_data_out <= shift;
            parity_err  <= par_bad;
            frame_err   <= (rx != UART_IDLE_LEVEL);
            rx_valid    <= 1'b1;
            state       <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx == UART_IDLE_LEVEL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
